// File: rtl/flow_proc_pkg.sv
// Shared types and constants for the flow_proc_sf store-and-forward packet buffer.
package flow_proc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } in_state_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/flow_proc_ram.sv
// Simple dual-port buffer memory: synchronous write, registered read with enable.
module flow_proc_ram #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register doubles as the output stage, so it holds while not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/flow_proc_sf.sv
// Store-and-forward packet buffer: commits whole packets, drops bad ones, streams on valid/ready.
// Optional statistics counters are enabled with the FLOW_PROC_STATS_EN macro.
module flow_proc_sf
    import flow_proc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int MAX_LEN    = 32,
    localparam int CNT_W     = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in_vld,
    input  logic                  sop_in_vld,
    input  logic                  eop_in_vld,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_out_vld,
    output logic                  sop_out_vld,
    output logic                  eop_out_vld,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  out_rdy,
    output logic                  fb_vld,
    output logic                  fb_eop,
    output logic [CNT_W-1:0]      fb_cnt,
`ifdef FLOW_PROC_STATS_EN
    output logic [STAT_W-1:0]     stat_pkt_cnt,
    output logic [STAT_W-1:0]     stat_drop_cnt,
`endif
    output logic                  drop_vld
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    in_state_e        r_state, w_state_d;
    logic [PW-1:0]    r_wr_tmp, w_wr_tmp_d;
    logic [PW-1:0]    r_wr_cmt, w_wr_cmt_d;
    logic [PW-1:0]    r_rd;
    logic [CNT_W-1:0] r_len, w_len_d;
    logic [PW-1:0]    w_base;
    logic             w_full;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic             w_drop;
    logic             r_drop;

    logic             r_out_vld;
    logic             w_rd_en;
    logic             w_xfer;
    logic [EW-1:0]    w_rdata;
    logic [CNT_W-1:0] r_out_len;
    logic             r_fb_vld;
    logic [CNT_W-1:0] r_fb_cnt;

    // A sop always restarts from the committed pointer, discarding any partial packet.
    assign w_base = sop_in_vld ? r_wr_cmt : r_wr_tmp;
    assign w_full = ((w_base - r_rd) == PW'(DEPTH));

    always_comb begin
        w_state_d  = r_state;
        w_wr_tmp_d = r_wr_tmp;
        w_wr_cmt_d = r_wr_cmt;
        w_len_d    = r_len;
        w_we       = 1'b0;
        w_waddr    = r_wr_tmp[AW-1:0];
        w_drop     = 1'b0;
        if (data_in_vld) begin
            if (sop_in_vld) begin
                if (r_state == RECV) begin
                    w_drop     = 1'b1;
                    w_wr_tmp_d = r_wr_cmt;
                end
                if (w_full) begin
                    w_drop     = 1'b1;
                    w_wr_tmp_d = r_wr_cmt;
                    w_state_d  = eop_in_vld ? IDLE : DROP;
                end else begin
                    w_we       = 1'b1;
                    w_waddr    = r_wr_cmt[AW-1:0];
                    w_wr_tmp_d = r_wr_cmt + 1'b1;
                    w_len_d    = CNT_W'(1);
                    if (eop_in_vld) begin
                        w_wr_cmt_d = r_wr_cmt + 1'b1;
                        w_state_d  = IDLE;
                    end else begin
                        w_state_d  = RECV;
                    end
                end
            end else begin
                unique case (r_state)
                    IDLE: ;
                    DROP: begin
                        if (eop_in_vld) begin
                            w_state_d = IDLE;
                        end
                    end
                    RECV: begin
                        if (r_len == CNT_W'(MAX_LEN) || w_full) begin
                            w_drop     = 1'b1;
                            w_wr_tmp_d = r_wr_cmt;
                            w_state_d  = eop_in_vld ? IDLE : DROP;
                        end else begin
                            w_we       = 1'b1;
                            w_wr_tmp_d = r_wr_tmp + 1'b1;
                            w_len_d    = r_len + 1'b1;
                            if (eop_in_vld) begin
                                w_wr_cmt_d = r_wr_tmp + 1'b1;
                                w_state_d  = IDLE;
                            end
                        end
                    end
                    default: w_state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wr_tmp <= '0;
            r_wr_cmt <= '0;
            r_len    <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_wr_tmp <= w_wr_tmp_d;
            r_wr_cmt <= w_wr_cmt_d;
            r_len    <= w_len_d;
            r_drop   <= w_drop;
        end
    end

    flow_proc_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_we),
        .i_wr_addr (w_waddr),
        .i_wr_data ({sop_in_vld, eop_in_vld, data_in}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd[AW-1:0]),
        .o_rd_data (w_rdata)
    );

    // Refill the output stage whenever it is empty or being emptied this cycle.
    assign w_xfer  = r_out_vld & out_rdy;
    assign w_rd_en = (r_rd != r_wr_cmt) & (~r_out_vld | out_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd      <= '0;
            r_out_vld <= 1'b0;
            r_out_len <= '0;
            r_fb_vld  <= 1'b0;
            r_fb_cnt  <= '0;
        end else begin
            if (w_rd_en) begin
                r_rd      <= r_rd + 1'b1;
                r_out_vld <= 1'b1;
            end else if (w_xfer) begin
                r_out_vld <= 1'b0;
            end
            r_fb_vld <= w_xfer & w_rdata[EW-2];
            r_fb_cnt <= '0;
            if (w_xfer) begin
                if (w_rdata[EW-2]) begin
                    r_out_len <= '0;
                    r_fb_cnt  <= r_out_len + 1'b1;
                end else begin
                    r_out_len <= r_out_len + 1'b1;
                end
            end
        end
    end

    assign data_out_vld = r_out_vld;
    assign sop_out_vld  = w_rdata[EW-1];
    assign eop_out_vld  = w_rdata[EW-2];
    assign data_out     = w_rdata[DATA_WIDTH-1:0];
    assign fb_vld       = r_fb_vld;
    assign fb_eop       = r_fb_vld;
    assign fb_cnt       = r_fb_cnt;
    assign drop_vld     = r_drop;

`ifdef FLOW_PROC_STATS_EN
    logic [STAT_W-1:0] r_stat_pkt;
    logic [STAT_W-1:0] r_stat_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_pkt  <= '0;
            r_stat_drop <= '0;
        end else begin
            if (r_fb_vld && r_stat_pkt != '1) begin
                r_stat_pkt <= r_stat_pkt + 1'b1;
            end
            if (r_drop && r_stat_drop != '1) begin
                r_stat_drop <= r_stat_drop + 1'b1;
            end
        end
    end

    assign stat_pkt_cnt  = r_stat_pkt;
    assign stat_drop_cnt = r_stat_drop;
`endif

endmodule

// File: doc/flow_proc_sf.md
Name: flow_proc_sf

Overview:
- Parametrised successor to flow_proc: a store-and-forward packet buffer on the vld/sop/eop/data packet bus.
- Accepts packets without backpressure and holds each one until its eop arrives. Malformed, oversized and overflowing packets are dropped in full.
- Committed packets are emitted on a valid/ready output. A per-packet feedback report (fb_vld/fb_eop/fb_cnt) is raised on completion.
- Sits between the packet generator interface (pkt_in_bus) and the downstream consumer (pkt_out_bus).

Parameters:
- DATA_WIDTH, 8, data bus width in bits.
- DEPTH, 64, buffer entries; power of two; must be >= MAX_LEN.
- MAX_LEN, 32, maximum packet length in beats; longer packets are dropped.
- CNT_W, $clog2(MAX_LEN+1) (localparam), width of the length counters.

Ports:
- clk  in  1  clock; the only clock in the block.
- rst  in  1  reset; asynchronous, active-high.
- data_in_vld  in  1  input beat valid.
- sop_in_vld  in  1  start of packet; qualified by data_in_vld.
- eop_in_vld  in  1  end of packet; qualified by data_in_vld.
- data_in  in  DATA_WIDTH  input data.
- data_out_vld  out  1  output beat valid.
- sop_out_vld  out  1  first beat of packet; qualified by data_out_vld.
- eop_out_vld  out  1  last beat of packet; qualified by data_out_vld.
- data_out  out  DATA_WIDTH  output data.
- out_rdy  in  1  downstream ready.
- fb_vld  out  1  one-cycle pulse: a packet's eop beat has transferred out.
- fb_eop  out  1  1 = packet delivered intact; always 1 when fb_vld=1.
- fb_cnt  out  CNT_W  beat count of the reported packet.
- drop_vld  out  1  one-cycle pulse: a packet was discarded.

Behaviour:
- Reset: all outputs 0; pointers 0; input FSM in IDLE. Asserting rst mid-packet discards any partial and buffered packets, with no fb or drop pulse.
- Buffer storage: {sop, eop, data} per entry. Pointers wr_tmp (speculative), wr_cmt (committed) and rd, each log2(DEPTH)+1 bits wide.
- Input FSM, IDLE:
  - Beat with sop → write the beat, len=1, go to RECV. If eop is also set, commit and stay in IDLE.
  - Beat without sop → discard silently; no drop_vld.
- Input FSM, RECV:
  - Beat without sop: write it, len+1. On eop, set wr_cmt=wr_tmp+1 and go to IDLE.
  - Beat with sop while in RECV (missing eop): roll back wr_tmp to wr_cmt, pulse drop_vld, and restart a new packet with this beat.
- Input FSM, DROP: discard beats until eop (inclusive), then go to IDLE. A beat with sop in DROP starts a new packet, as in IDLE.
- Drop conditions: len would exceed MAX_LEN, or wr_tmp-rd == DEPTH (full) on a valid beat. Either one: roll back wr_tmp to wr_cmt, pulse drop_vld once, go to DROP (or IDLE if that beat carried eop).
- Output path: only committed entries are readable (rd != wr_cmt).
  - Registered read with a one-entry output stage. If eop is sampled in cycle N, data_out_vld rises in cycle N+2 at the earliest.
  - Transfer on data_out_vld & out_rdy. data_out and flags hold stable while vld=1 and rdy=0.
  - Back-to-back packets stream with no idle cycles while out_rdy=1.
- Feedback: an output length counter counts transfers. On the eop transfer: fb_vld=1, fb_eop=1, fb_cnt=packet length for one cycle; otherwise fb_* = 0.
- Simultaneous events:
  - A drop and an output eop in the same cycle each raise their own pulse.
  - A write and a read in the same cycle when full → the read frees space on the next cycle only; the full check uses the pre-edge rd.
- Pointer wrap: natural modulo 2*DEPTH through the extra MSB.

Optional Feature:
- Macro: FLOW_PROC_STATS_EN.
- Defined: adds output ports stat_pkt_cnt [15:0] (packets delivered, incremented on fb_vld) and stat_drop_cnt [15:0] (incremented on drop_vld). Both saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and their counters are absent, and behaviour is otherwise identical.

Decomposition:
- flow_proc_pkg: in_state_e {IDLE, RECV, DROP}; localparam STAT_W=16.
- Sub-module flow_proc_ram: simple dual-port memory, DEPTH x (DATA_WIDTH+2), with synchronous write and registered read.

Test Plan:
- Single 4-beat packet (sop at beat 0, eop at beat 3, data 0x10-0x13), out_rdy=1 → outputs 0x10-0x13 starting 2 cycles after eop, with sop/eop flags correct; then fb_vld for 1 cycle with fb_cnt=4.
- Single-beat packet (sop+eop, data 0xA5) → one output beat with sop=eop=1; fb_cnt=1.
- 33-beat packet with MAX_LEN=32 → drop_vld pulse at beat 33; no output; a following 2-beat packet delivered with fb_cnt=2.
- sop, 2 beats, then a new sop without eop → drop_vld; only the second packet is output.
- out_rdy=0 while 3 x 32-beat packets arrive (DEPTH=64) → third packet dropped. With out_rdy=1, first two packets delivered intact with fb_cnt=32 each.
- rst asserted mid-output of a packet → all outputs 0 immediately; after release, no stale beats and a new packet passes normally.
